// File: rtl/change_pkg.sv
// Shared definitions for the dispense_change coin-change calculator.
//   QUARTER_C / DIME_C / NICKEL_C : coin values in cents
//   COUNT_W_C                     : width of each coin count
//   MAX_CHANGE                    : largest amount whose quarter count fits COUNT_W_C
//   CHG_IN_W                      : bits needed to hold any in-range amount
//   coin_counts_t                 : the four coin counts as one record
package change_pkg;

    localparam int QUARTER_C  = 25;
    localparam int DIME_C     = 10;
    localparam int NICKEL_C   = 5;
    localparam int COUNT_W_C  = 9;
    localparam int MAX_CHANGE = 12799;
    localparam int CHG_IN_W   = $clog2(MAX_CHANGE + 1);

    typedef struct packed {
        logic [COUNT_W_C-1:0] quarters;
        logic [COUNT_W_C-1:0] dimes;
        logic [COUNT_W_C-1:0] nickels;
        logic [COUNT_W_C-1:0] pennies;
    } coin_counts_t;

endpackage

// File: rtl/dispense_change_if.sv
// Bundle of the change amount and its coin breakdown.
//   master : drives change, observes the breakdown (payment datapath side)
//   slave  : receives change, drives the breakdown (calculator side)
interface dispense_change_if #(
    parameter int CHANGE_W = 32,
    parameter int COUNT_W  = 9
);
    logic [CHANGE_W-1:0] change;
    logic [COUNT_W-1:0]  quarters;
    logic [COUNT_W-1:0]  dimes;
    logic [COUNT_W-1:0]  nickels;
    logic [COUNT_W-1:0]  pennies;
    logic                overflow;

    modport master (
        output change,
        input  quarters, dimes, nickels, pennies, overflow
    );

    modport slave (
        input  change,
        output quarters, dimes, nickels, pennies, overflow
    );
endinterface

// File: rtl/dispense_change_divmod.sv
// Combinational divide/modulo by a constant divisor.
//   x : dividend (IN_W bits)
//   q : quotient, truncated to Q_W bits
//   r : remainder, truncated to R_W bits
// Callers size Q_W/R_W to the largest value their dividend range can yield.
module coin_divmod #(
    parameter int IN_W    = 14,
    parameter int DIVISOR = 25,
    parameter int Q_W     = 9,
    parameter int R_W     = 5
) (
    input  logic [IN_W-1:0] x,
    output logic [Q_W-1:0]  q,
    output logic [R_W-1:0]  r
);
    localparam logic [IN_W-1:0] DIV_L = IN_W'(DIVISOR);

    // Constant-divisor quotient and remainder.
    always_comb begin
        q = Q_W'(x / DIV_L);
        r = R_W'(x % DIV_L);
    end
endmodule

// File: rtl/dispense_change.sv
// Registered greedy coin-change calculator.
//   change   : amount in cents (unsigned)
//   quarters/dimes/nickels/pennies : minimum-coin breakdown, one cycle later
//   overflow : amount exceeded MAX_CHANGE; all counts saturate to all-ones
//   clk, rst_n : clock, synchronous active-low reset
// Port order is fixed for positional instantiation.
module dispense_change
    import change_pkg::*;
#(
    parameter int CHANGE_W = 32,
    parameter int COUNT_W  = 9
) (
    input  logic [CHANGE_W-1:0] change,
    output logic [COUNT_W-1:0]  quarters,
    output logic [COUNT_W-1:0]  dimes,
    output logic [COUNT_W-1:0]  nickels,
    output logic [COUNT_W-1:0]  pennies,
    output logic                overflow,
    input  logic                clk,
    input  logic                rst_n
);
    logic                 w_in_range;
    logic [COUNT_W_C-1:0] w_q;
    logic [4:0]           w_r1;
    logic [1:0]           w_d;
    logic [3:0]           w_r2;
    logic                 w_n;
    logic [2:0]           w_p;
    coin_counts_t         w_next;
    coin_counts_t         r_counts;
    logic                 r_overflow;

    assign w_in_range = (change <= CHANGE_W'(MAX_CHANGE));

    // Only the low CHG_IN_W bits matter when in range; out of range the
    // divider results are discarded by the saturation mux.
    coin_divmod #(.IN_W(CHG_IN_W), .DIVISOR(QUARTER_C), .Q_W(COUNT_W_C), .R_W(5)) u_div25 (
        .x (change[CHG_IN_W-1:0]),
        .q (w_q),
        .r (w_r1)
    );

    coin_divmod #(.IN_W(5), .DIVISOR(DIME_C), .Q_W(2), .R_W(4)) u_div10 (
        .x (w_r1),
        .q (w_d),
        .r (w_r2)
    );

    coin_divmod #(.IN_W(4), .DIVISOR(NICKEL_C), .Q_W(1), .R_W(3)) u_div5 (
        .x (w_r2),
        .q (w_n),
        .r (w_p)
    );

    // Select greedy counts in range, all-ones saturation otherwise.
    always_comb begin
        w_next = '0;
        if (w_in_range) begin
            w_next.quarters = w_q;
            w_next.dimes    = COUNT_W_C'(w_d);
            w_next.nickels  = COUNT_W_C'(w_n);
            w_next.pennies  = COUNT_W_C'(w_p);
        end else begin
            w_next.quarters = '1;
            w_next.dimes    = '1;
            w_next.nickels  = '1;
            w_next.pennies  = '1;
        end
    end

    // Output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_counts   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_counts   <= w_next;
            r_overflow <= ~w_in_range;
        end
    end

    assign quarters = COUNT_W'(r_counts.quarters);
    assign dimes    = COUNT_W'(r_counts.dimes);
    assign nickels  = COUNT_W'(r_counts.nickels);
    assign pennies  = COUNT_W'(r_counts.pennies);
    assign overflow = r_overflow;
endmodule

// File: tb/tb_dispense_change.sv
// Directed and random self-checking bench for dispense_change.
module tb_dispense_change;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    dispense_change_if #(.CHANGE_W(32), .COUNT_W(9)) bus ();

    dispense_change #(.CHANGE_W(32), .COUNT_W(9)) dut (
        .change   (bus.change),
        .quarters (bus.quarters),
        .dimes    (bus.dimes),
        .nickels  (bus.nickels),
        .pennies  (bus.pennies),
        .overflow (bus.overflow),
        .clk      (clk),
        .rst_n    (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack of expected/observed outputs: {q,d,n,p,ovf} = 37 bits
    function automatic logic [36:0] observed();
        return {bus.quarters, bus.dimes, bus.nickels, bus.pennies, bus.overflow};
    endfunction

    function automatic logic [36:0] pack(int q, int d, int n, int p, int o);
        logic [8:0] qq, dd, nn, pp;
        qq = q[8:0]; dd = d[8:0]; nn = n[8:0]; pp = p[8:0];
        return {qq, dd, nn, pp, o[0]};
    endfunction

    // Independent reference: greedy breakdown with saturation.
    function automatic logic [36:0] model(logic [31:0] v);
        int q, d, n, p;
        if (v > 32'd12799) return pack(511, 511, 511, 511, 1);
        q = int'(v) / 25;
        d = (int'(v) % 25) / 10;
        n = ((int'(v) % 25) % 10) / 5;
        p = int'(v) % 5;
        return pack(q, d, n, p, 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [36:0] obs;
        rst_n = 1'b0;
        bus.change = 32'd37;
        step();
        step();
        obs = observed();
        tests++;
        if (obs !== pack(0, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL reset_hold: got %h want %h", obs, pack(0, 0, 0, 0, 0));
        end
        rst_n = 1'b1;
        step();
        obs = observed();
        tests++;
        if (obs !== pack(1, 1, 0, 2, 0)) begin
            fails++;
            $display("FAIL reset_release: got %h want %h", obs, pack(1, 1, 0, 2, 0));
        end
    endtask

    task automatic test_basic();
        logic [31:0] vin [4] = '{32'd0, 32'd99, 32'd40, 32'd5};
        logic [36:0] exp [4];
        logic [36:0] obs;
        exp[0] = pack(0, 0, 0, 0, 0);
        exp[1] = pack(3, 2, 0, 4, 0);
        exp[2] = pack(1, 1, 1, 0, 0);
        exp[3] = pack(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bus.change = vin[i];
            step();
            obs = observed();
            tests++;
            if (obs !== exp[i]) begin
                fails++;
                $display("FAIL basic change=%0d: got %h want %h", vin[i], obs, exp[i]);
            end
        end
    endtask

    task automatic test_boundary();
        logic [31:0] vin [3] = '{32'd12799, 32'd12800, 32'hFFFF_FFFF};
        logic [36:0] exp [3];
        logic [36:0] obs;
        exp[0] = pack(511, 2, 0, 4, 0);
        exp[1] = pack(511, 511, 511, 511, 1);
        exp[2] = pack(511, 511, 511, 511, 1);
        for (int i = 0; i < 3; i++) begin
            bus.change = vin[i];
            step();
            obs = observed();
            tests++;
            if (obs !== exp[i]) begin
                fails++;
                $display("FAIL boundary change=%0h: got %h want %h", vin[i], obs, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vin [4] = '{32'd37, 32'd99, 32'd12800, 32'd4};
        logic [36:0] exp [4];
        logic [36:0] prev;
        logic [36:0] obs;
        exp[0] = pack(1, 1, 0, 2, 0);
        exp[1] = pack(3, 2, 0, 4, 0);
        exp[2] = pack(511, 511, 511, 511, 1);
        exp[3] = pack(0, 0, 0, 4, 0);
        bus.change = 32'd0;
        step();
        prev = pack(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bus.change = vin[i];
            #1;
            // Registered: a mid-cycle input change must not reach the outputs.
            obs = observed();
            tests++;
            if (obs !== prev) begin
                fails++;
                $display("FAIL b2b_hold idx=%0d: got %h want %h", i, obs, prev);
            end
            step();
            obs = observed();
            tests++;
            if (obs !== exp[i]) begin
                fails++;
                $display("FAIL b2b idx=%0d: got %h want %h", i, obs, exp[i]);
            end
            prev = exp[i];
        end
    endtask

    task automatic test_reset_midstream();
        logic [36:0] obs;
        bus.change = 32'd99;
        step();
        rst_n = 1'b0;
        step();
        obs = observed();
        tests++;
        if (obs !== pack(0, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL mid_reset: got %h want %h", obs, pack(0, 0, 0, 0, 0));
        end
        rst_n = 1'b1;
        step();
        obs = observed();
        tests++;
        if (obs !== pack(3, 2, 0, 4, 0)) begin
            fails++;
            $display("FAIL mid_reset_release: got %h want %h", obs, pack(3, 2, 0, 4, 0));
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [36:0] obs;
        logic [36:0] exp;
        int          sum;
        int          sweep_fails;
        sweep_fails = 0;
        for (int i = 0; i < 10000; i++) begin
            v = 32'($urandom_range(0, 20000));
            bus.change = v;
            step();
            obs = observed();
            exp = model(v);
            tests++;
            if (obs !== exp) begin
                fails++;
                sweep_fails++;
                if (sweep_fails < 10)
                    $display("FAIL random change=%0d: got %h want %h", v, obs, exp);
            end
            if (bus.overflow === 1'b0) begin
                sum = int'(bus.quarters) * 25 + int'(bus.dimes) * 10
                    + int'(bus.nickels) * 5 + int'(bus.pennies);
                tests++;
                if (sum !== int'(v)) begin
                    fails++;
                    sweep_fails++;
                    if (sweep_fails < 10)
                        $display("FAIL conserve change=%0d: got %0d want %0d", v, sum, v);
                end
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.change = 32'd0;
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dispense_change.md
# dispense_change

Registered greedy coin-change calculator. Takes an amount in cents and, one clock later, presents the minimum-coin breakdown into quarters, dimes, nickels and pennies. It sits at the output of the vending/payment datapath, after the change amount is computed and before the coin-dispenser drivers.

## Interface
Parameters:
- `CHANGE_W`, 32: width of the cents input.
- `COUNT_W`, 9: width of each coin-count output.

Ports. Clock and reset are listed first here, but declaration order is fixed, because existing benches instantiate positionally: `change, quarters, dimes, nickels, pennies, overflow, clk, rst_n`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `change`  in  CHANGE_W  amount in cents, unsigned.
- `quarters`  out  COUNT_W  number of 25-cent coins.
- `dimes`  out  COUNT_W  number of 10-cent coins.
- `nickels`  out  COUNT_W  number of 5-cent coins.
- `pennies`  out  COUNT_W  number of 1-cent coins.
- `overflow`  out  1  high when `change` exceeds the maximum amount representable.

## Operation
- Greedy breakdown:
  - q = change / 25; r1 = change mod 25
  - d = r1 / 10; r2 = r1 mod 10
  - n = r2 / 5; p = r2 mod 5
- Value ranges:
  - d is always 0..2, n is 0..1, p is 0..4.
  - q is the only count that can exceed its width.
- Maximum representable amount: MAX_CHANGE = 511*25 + 24 = 12799 cents.
- In range (change ≤ 12799):
  - Outputs take the greedy values, zero-extended to COUNT_W.
  - `overflow` = 0.
- Out of range (change > 12799):
  - quarters = dimes = nickels = pennies = 511.
  - `overflow` = 1.
- All arithmetic is unsigned. Divisors are constants; no runtime division by zero is possible.
- There is no handshake and no valid signal. The block recomputes every cycle from the current `change`.

## Timing
- While rst_n = 0 at a rising edge, all outputs become 0 and `overflow` = 0.
- Reset takes precedence over any `change` value, including assertion mid-stream.
- First valid result appears on the edge after rst_n is sampled high.
- Latency is exactly 1 cycle. Outputs at edge k+1 reflect `change` sampled at edge k.
- Throughput is one new amount per cycle. Back-to-back changes of `change` produce back-to-back results.
- Outputs are registered and hold stable between edges. They do not glitch when `change` toggles mid-cycle.
- The combinational path from `change` to the output registers must close within one clock period at the target frequency.
  - If it does not, implement the divide stage as constant-multiply/shift.
  - Latency must not change.

## Structure
- Shared package `change_pkg` holds:
  - coin value constants QUARTER_C = 25, DIME_C = 10, NICKEL_C = 5;
  - MAX_CHANGE = 12799;
  - a struct type `coin_counts_t` containing the four COUNT_W counts.
- One sub-module `coin_divmod`:
  - parameterised by divisor;
  - combinational; returns quotient and remainder;
  - instantiated three times: ÷25, ÷10, ÷5.
- The top level contains the range check, the saturation mux and the output registers.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with change = 37 → all counts 0, overflow = 0; release → 1 cycle later 1 quarter, 1 dime, 0 nickels, 2 pennies.
- change = 0 → 0/0/0/0; change = 99 → 3/2/0/4; change = 40 → 1/1/1/0; change = 5 → 0/0/1/0.
- Boundary: change = 12799 → 511/2/0/4, overflow = 0; change = 12800 → 511/511/511/511, overflow = 1; change = 32'hFFFF_FFFF → same saturated result.
- Latency/throughput: apply 37, 99, 12800, 4 on consecutive edges → results appear one cycle later, in order, with no bubbles.
- Reset mid-stream: assert rst_n = 0 for one cycle while change = 99 → outputs 0 at that edge; next edge after release → 3/2/0/4.
- Random sweep: 10k random values in 0..20000, compared against the greedy reference model with the saturation rule; check that q*25 + d*10 + n*5 + p equals change whenever overflow = 0.
